// File: rtl/serializer_arbiter.sv
// Round-robin arbiter sharing one serializer among N_REQ requesters.
// One word is issued per grant; the next grant waits for the serializer busy pulse to finish.
module serializer_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MOD_W    = 4,
  parameter int unsigned BUSY_TMO = 4
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  input  logic [N_REQ*MOD_W-1:0]    req_mod_i,
  input  logic [N_REQ-1:0]          req_val_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [DATA_W-1:0]         ser_data_o,
  output logic [MOD_W-1:0]          ser_mod_o,
  output logic                      ser_val_o,
  input  logic                      ser_busy_i,
  output logic [$clog2(N_REQ)-1:0]  grant_id_o,
  output logic                      busy_o,
  output logic                      drop_o,
  output logic                      tmo_o
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitB, StWaitD} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [IdW-1:0]    id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MOD_W-1:0]  mod_q, mod_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              tmo;

  logic [IdW-1:0]    pick;
  logic              pick_vld;
  int unsigned       rr_idx;
  logic [DATA_W-1:0] sel_data;
  logic [MOD_W-1:0]  sel_mod;
  logic              can_grant;
  logic              xfer;
  logic              is_drop;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    rr_idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      rr_idx = (32'(ptr_q) + k) % N_REQ;
      if (!pick_vld && req_val_i[rr_idx]) begin
        pick     = IdW'(rr_idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_mod  = '0;
    for (int unsigned r = 0; r < N_REQ; r++) begin
      if (pick == IdW'(r)) begin
        sel_data = req_data_i[r*DATA_W +: DATA_W];
        sel_mod  = req_mod_i[r*MOD_W +: MOD_W];
      end
    end
  end

  assign can_grant = (state_q == StIdle) && !ser_busy_i && !srst_i;
  assign xfer      = can_grant && pick_vld;
  assign is_drop   = (sel_mod == MOD_W'(1)) || (sel_mod == MOD_W'(2));

  always_comb begin
    req_ready_o = '0;
    if (xfer) begin
      req_ready_o[pick] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    data_d  = data_q;
    mod_d   = mod_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          id_d    = pick;
          data_d  = sel_data;
          mod_d   = sel_mod;
          ptr_d   = (pick == IdW'(N_REQ - 1)) ? '0 : pick + 1'b1;
          drop_d  = is_drop;
          state_d = is_drop ? StIdle : StIssue;
        end
      end
      StIssue: begin
        state_d = StWaitB;
        cnt_d   = '0;
      end
      StWaitB: begin
        if (ser_busy_i) begin
          state_d = StWaitD;
        end else if (cnt_q == CntW'(BUSY_TMO - 1)) begin
          state_d = StIdle;
          tmo     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitD: begin
        if (!ser_busy_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign ser_val_o  = (state_q == StIssue);
  assign ser_data_o = data_q;
  assign ser_mod_o  = mod_q;
  assign grant_id_o = id_q;
  assign busy_o     = (state_q != StIdle);
  assign drop_o     = drop_q;
  // Timeout fires on the last waiting cycle, as the FSM falls back to idle.
  assign tmo_o      = tmo && !srst_i;

endmodule

// File: tb/tb_serializer_arbiter.sv
// Randomized bench for serializer_arbiter against a transaction-level round-robin model.
module tb_serializer_arbiter;

  localparam int N = 4;
  localparam int DW = 16;
  localparam int MW = 4;
  localparam int TMO = 4;

  logic            clk_i = 1'b0;
  logic            srst_i;
  logic [N*DW-1:0] req_data_i;
  logic [N*MW-1:0] req_mod_i;
  logic [N-1:0]    req_val_i;
  logic [N-1:0]    req_ready_o;
  logic [DW-1:0]   ser_data_o;
  logic [MW-1:0]   ser_mod_o;
  logic            ser_val_o;
  logic            ser_busy_i;
  logic [1:0]      grant_id_o;
  logic            busy_o;
  logic            drop_o;
  logic            tmo_o;

  serializer_arbiter #(
    .N_REQ(N), .DATA_W(DW), .MOD_W(MW), .BUSY_TMO(TMO)
  ) dut (
    .clk_i(clk_i), .srst_i(srst_i), .req_data_i(req_data_i), .req_mod_i(req_mod_i),
    .req_val_i(req_val_i), .req_ready_o(req_ready_o), .ser_data_o(ser_data_o),
    .ser_mod_o(ser_mod_o), .ser_val_o(ser_val_o), .ser_busy_i(ser_busy_i),
    .grant_id_o(grant_id_o), .busy_o(busy_o), .drop_o(drop_o), .tmo_o(tmo_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_bad = 0;

  logic [DW-1:0] wdata [N];
  logic [MW-1:0] wmod  [N];
  logic [N-1:0]  val;
  int            ptr_m;
  bit            auto_refresh;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply();
    for (int r = 0; r < N; r++) begin
      req_data_i[r*DW +: DW] = wdata[r];
      req_mod_i[r*MW +: MW]  = wmod[r];
    end
    req_val_i = val;
  endtask

  function automatic int pick_rr(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_data"}, 32'(ser_data_o), 0);
    check_eq({tag, "_mod"}, 32'(ser_mod_o), 0);
    check_eq({tag, "_val"}, 32'(ser_val_o), 0);
    check_eq({tag, "_gid"}, 32'(grant_id_o), 0);
    check_eq({tag, "_busy"}, 32'(busy_o), 0);
    check_eq({tag, "_drop"}, 32'(drop_o), 0);
    check_eq({tag, "_tmo"}, 32'(tmo_o), 0);
  endtask

  task automatic do_reset();
    srst_i     = 1'b1;
    ser_busy_i = 1'b0;
    tick();
    check_all_zero("rst");
    check_eq("rst_ready", 32'(req_ready_o), 0);
    srst_i = 1'b0;
    ptr_m  = 0;
  endtask

  // One arbitration round starting in IDLE. len == 0 models a serializer that never goes busy;
  // otherwise busy rises d cycles into the wait and stays high for len cycles.
  task automatic round(input int d, input int len);
    int            g;
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] wd;
    logic [MW-1:0] wm;
    bit            drop;
    #1;
    g       = pick_rr(val, ptr_m);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("ready", 32'(req_ready_o), 32'(exp_rdy));
    if (g < 0) begin
      tick();
      return;
    end
    wd    = wdata[g];
    wm    = wmod[g];
    drop  = (wm == 1) || (wm == 2);
    ptr_m = (g + 1) % N;
    tick();
    if (auto_refresh) begin
      val[g]   = 1'($urandom_range(0, 1));
      wdata[g] = 16'($urandom);
      wmod[g]  = 4'($urandom_range(0, 15));
      apply();
    end
    #1;
    if (drop) begin
      check_eq("drop_pulse", 32'(drop_o), 1);
      check_eq("drop_noval", 32'(ser_val_o), 0);
      check_eq("drop_idle", 32'(busy_o), 0);
      return;
    end
    check_eq("issue_val", 32'(ser_val_o), 1);
    check_eq("issue_data", 32'(ser_data_o), 32'(wd));
    check_eq("issue_mod", 32'(ser_mod_o), 32'(wm));
    check_eq("issue_gid", 32'(grant_id_o), 32'(g));
    check_eq("issue_busy", 32'(busy_o), 1);
    check_eq("issue_ready", 32'(req_ready_o), 0);
    tick();
    if (len == 0) begin
      for (int i = 0; i < TMO; i++) begin
        #1;
        check_eq("tmo_pulse", 32'(tmo_o), (i == TMO - 1) ? 1 : 0);
        check_eq("tmo_busy", 32'(busy_o), 1);
        check_eq("tmo_noval", 32'(ser_val_o), 0);
        tick();
      end
    end else begin
      for (int i = 0; i <= d + len; i++) begin
        ser_busy_i = (i >= d) && (i < d + len);
        #1;
        check_eq("wait_busy", 32'(busy_o), 1);
        check_eq("wait_ready", 32'(req_ready_o), 0);
        check_eq("wait_tmo", 32'(tmo_o), 0);
        check_eq("wait_noval", 32'(ser_val_o), 0);
        tick();
      end
    end
    ser_busy_i = 1'b0;
    #1;
    check_eq("end_idle", 32'(busy_o), 0);
    check_eq("end_tmo", 32'(tmo_o), 0);
  endtask

  initial begin
    int g;
    auto_refresh = 1'b0;
    srst_i       = 1'b1;
    ser_busy_i   = 1'b0;
    for (int r = 0; r < N; r++) begin
      wdata[r] = 16'(16'h1111 * (r + 1));
      wmod[r]  = 4'(r + 3);
    end
    val = '0;
    apply();
    tick();
    do_reset();

    // Single requester word, 16-cycle serializer busy.
    wdata[0] = 16'hA5C3;
    wmod[0]  = 4'd0;
    val      = 4'b0001;
    apply();
    round(1, 16);

    // All requesters valid: 0,1,2,3,0 then steer pointer to 2.
    do_reset();
    val = 4'b1111;
    apply();
    for (int i = 0; i < 5; i++) round(i % TMO, 2);
    val = 4'b0010;
    apply();
    round(0, 1);

    // Pointer at 2 with only 1 and 3 valid.
    val = 4'b1010;
    apply();
    round(2, 3);
    round(0, 2);

    // Discarded word, then pointer must sit at 3.
    val     = 4'b0100;
    wmod[2] = 4'd1;
    apply();
    round(0, 1);
    wmod[2] = 4'd6;
    val     = 4'b1111;
    apply();
    round(1, 1);

    // Serializer never goes busy, then a normal grant follows.
    val = 4'b0001;
    apply();
    round(0, 0);
    round(0, 2);

    // Reset while waiting for busy to fall; serializer still busy afterwards.
    val = 4'b0010;
    apply();
    #1;
    g = pick_rr(val, ptr_m);
    check_eq("r6_pick", 32'(req_ready_o), 32'(1 << g));
    tick();
    check_eq("r6_issue", 32'(ser_val_o), 1);
    tick();
    ser_busy_i = 1'b1;
    tick();
    check_eq("r6_waitd", 32'(busy_o), 1);
    srst_i = 1'b1;
    val    = 4'b1111;
    apply();
    tick();
    check_all_zero("r6");
    srst_i = 1'b0;
    ptr_m  = 0;
    #1;
    check_eq("r6_busy_block", 32'(req_ready_o), 0);
    tick();
    ser_busy_i = 1'b0;
    round(0, 2);

    // Randomized traffic.
    auto_refresh = 1'b1;
    for (int n = 0; n < 80; n++) begin
      for (int r = 0; r < N; r++) begin
        if (!val[r] && ($urandom_range(0, 2) == 0)) begin
          val[r]   = 1'b1;
          wdata[r] = 16'($urandom);
          wmod[r]  = 4'($urandom_range(0, 15));
        end
      end
      apply();
      if ($urandom_range(0, 4) == 0) round(0, 0);
      else round(int'($urandom_range(0, TMO - 1)), int'($urandom_range(1, 6)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
